rf_bypass16: RTL and testbench

//  Register file with internal write-to-read bypass; feeds the operand-select
//  16-bit 2:1 muxes in decode (read data -> inA, immediate/forwarded -> inB).
//  Two combinational read ports, one synchronous write port. A same-cycle write
//  to a register being read is returned on the read port, so write-back and

---
 rtl/rf_bypass16_if.sv | 29 ++
 rtl/rf_bypass16.sv | 63 ++++++
 tb/tb_rf_bypass16.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rf_bypass16_if.sv
// Register-file access bundle: two read selects with returned data/bypass flags, one write port.
// Latency: purely a signal bundle, no timing of its own.
// Backpressure: none; the register file accepts a write every cycle.
interface rf_bypass16_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 3
) ();
  logic [SEL_W-1:0] read1RegSel;
  logic [SEL_W-1:0] read2RegSel;
  logic [SEL_W-1:0] writeRegSel;
  logic [WIDTH-1:0] writeData;
  logic             write;
  logic [WIDTH-1:0] read1Data;
  logic [WIDTH-1:0] read2Data;
  logic             bypass1;
  logic             bypass2;

  // Decode/write-back side: drives selects and write data, consumes read data.
  modport master (
    output read1RegSel, read2RegSel, writeRegSel, writeData, write,
    input  read1Data, read2Data, bypass1, bypass2
  );

  // Register file side.
  modport slave (
    input  read1RegSel, read2RegSel, writeRegSel, writeData, write,
    output read1Data, read2Data, bypass1, bypass2
  );
endinterface

// File: rtl/rf_bypass16.sv
// Register file, 2 combinational read ports + 1 synchronous write port, same-cycle write-to-read bypass.
// Latency: reads zero-cycle; writes visible in storage after the rising edge, and via bypass in the write cycle.
// Backpressure: none; a write may be issued every cycle.
module rf_bypass16 #(
  parameter int WIDTH    = 16,
  parameter int SEL_W    = 3,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  rf_bypass16_if.slave  bus
);
  localparam int NREG = 2 ** SEL_W;

  logic [WIDTH-1:0] r_regs [NREG];
  logic             w_wr_ok;
  logic             w_rd1_zero;
  logic             w_rd2_zero;
  logic             w_byp1;
  logic             w_byp2;

  // A write to register 0 is dropped when it is hardwired to zero.
  assign w_wr_ok    = bus.write && !(ZERO_REG && (bus.writeRegSel == '0));
  assign w_rd1_zero = ZERO_REG && (bus.read1RegSel == '0);
  assign w_rd2_zero = ZERO_REG && (bus.read2RegSel == '0);

  // Storage update: reset clears everything and overrides a concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[bus.writeRegSel] <= bus.writeData;
    end
  end

  // Bypass only when the write will actually land, so reset suppresses it.
  always_comb begin
    w_byp1 = bus.write && !rst && (bus.writeRegSel == bus.read1RegSel) && !w_rd1_zero;
    w_byp2 = bus.write && !rst && (bus.writeRegSel == bus.read2RegSel) && !w_rd2_zero;
  end

  // Read muxes: forced zero, then in-flight write data, then stored value.
  always_comb begin
    bus.bypass1 = w_byp1;
    bus.bypass2 = w_byp2;
    if (w_rd1_zero) begin
      bus.read1Data = '0;
    end else if (w_byp1) begin
      bus.read1Data = bus.writeData;
    end else begin
      bus.read1Data = r_regs[bus.read1RegSel];
    end
    if (w_rd2_zero) begin
      bus.read2Data = '0;
    end else if (w_byp2) begin
      bus.read2Data = bus.writeData;
    end else begin
      bus.read2Data = r_regs[bus.read2RegSel];
    end
  end
endmodule

// File: tb/tb_rf_bypass16.sv
// Bench for rf_bypass16: one instance with ZERO_REG=0 and one with ZERO_REG=1 driven identically.
// Latency: outputs sampled mid-cycle against a reference memory updated at each rising edge.
// Backpressure: not applicable.
module tb_rf_bypass16;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  // Reference storage per instance (index 0: ZERO_REG=0, index 1: ZERO_REG=1).
  logic [15:0] mem [2][8];

  // Last sampled outputs, per instance.
  logic [15:0] s_rd1 [2];
  logic [15:0] s_rd2 [2];
  logic        s_bp1 [2];
  logic        s_bp2 [2];

  rf_bypass16_if #(.WIDTH(16), .SEL_W(3)) if0 ();
  rf_bypass16_if #(.WIDTH(16), .SEL_W(3)) if1 ();

  rf_bypass16 #(.WIDTH(16), .SEL_W(3), .ZERO_REG(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  rf_bypass16 #(.WIDTH(16), .SEL_W(3), .ZERO_REG(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit exp_byp(int z, bit r, bit w, int ws, int s);
    return w && !r && (ws == s) && !(z == 1 && s == 0);
  endfunction

  function automatic logic [15:0] exp_data(int z, bit r, bit w, int ws, logic [15:0] wd, int s);
    if (z == 1 && s == 0) return 16'h0000;
    if (exp_byp(z, r, w, ws, s)) return wd;
    return mem[z][s];
  endfunction

  // One cycle: drive at posedge+1, check at posedge+3, advance model at the next posedge.
  task automatic step(input bit r, input bit w, input int ws, input logic [15:0] wd,
                      input int s1, input int s2);
    rst = r;
    if0.write = w;  if0.writeRegSel = 3'(ws); if0.writeData = wd;
    if0.read1RegSel = 3'(s1); if0.read2RegSel = 3'(s2);
    if1.write = w;  if1.writeRegSel = 3'(ws); if1.writeData = wd;
    if1.read1RegSel = 3'(s1); if1.read2RegSel = 3'(s2);
    #2;
    s_rd1[0] = if0.read1Data; s_rd2[0] = if0.read2Data; s_bp1[0] = if0.bypass1; s_bp2[0] = if0.bypass2;
    s_rd1[1] = if1.read1Data; s_rd2[1] = if1.read2Data; s_bp1[1] = if1.bypass1; s_bp2[1] = if1.bypass2;
    for (int z = 0; z < 2; z++) begin
      check($sformatf("z%0d_rd1_sel%0d", z, s1), 32'(s_rd1[z]), 32'(exp_data(z, r, w, ws, wd, s1)));
      check($sformatf("z%0d_rd2_sel%0d", z, s2), 32'(s_rd2[z]), 32'(exp_data(z, r, w, ws, wd, s2)));
      check($sformatf("z%0d_bp1_sel%0d", z, s1), 32'(s_bp1[z]), 32'(exp_byp(z, r, w, ws, s1)));
      check($sformatf("z%0d_bp2_sel%0d", z, s2), 32'(s_bp2[z]), 32'(exp_byp(z, r, w, ws, s2)));
    end
    @(posedge clk);
    for (int z = 0; z < 2; z++) begin
      if (r) begin
        for (int k = 0; k < 8; k++) mem[z][k] = 16'h0000;
      end else if (w && !(z == 1 && ws == 0)) begin
        mem[z][ws] = wd;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if0.write = 1'b0; if0.writeRegSel = '0; if0.writeData = '0;
    if0.read1RegSel = '0; if0.read2RegSel = '0;
    if1.write = 1'b0; if1.writeRegSel = '0; if1.writeData = '0;
    if1.read1RegSel = '0; if1.read2RegSel = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int z = 0; z < 2; z++)
      for (int k = 0; k < 8; k++) mem[z][k] = 16'h0000;

    // Reset state: every register reads zero on both ports.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 0, 16'h0, i, 7 - i);
      check("rst_rd1", 32'(s_rd1[0]), 32'h0);
      check("rst_rd2", 32'(s_rd2[0]), 32'h0);
    end

    // Plain write then read back.
    step(1'b0, 1'b1, 3, 16'hBEEF, 0, 0);
    step(1'b0, 1'b0, 0, 16'h0, 3, 3);
    check("wr_r3_rd1", 32'(s_rd1[0]), 32'hBEEF);
    check("wr_r3_rd2", 32'(s_rd2[0]), 32'hBEEF);
    check("wr_r3_bp1", 32'(s_bp1[0]), 32'h0);
    step(1'b0, 1'b0, 0, 16'h0, 2, 4);
    check("r2_clean", 32'(s_rd1[0]), 32'h0);
    check("r4_clean", 32'(s_rd2[0]), 32'h0);

    // Same-cycle bypass on one port only.
    step(1'b0, 1'b1, 6, 16'h6666, 0, 0);
    step(1'b0, 1'b1, 5, 16'h1234, 5, 6);
    check("byp_rd1", 32'(s_rd1[0]), 32'h1234);
    check("byp_bp1", 32'(s_bp1[0]), 32'h1);
    check("byp_rd2_old", 32'(s_rd2[0]), 32'h6666);
    check("byp_bp2", 32'(s_bp2[0]), 32'h0);

    // Reset wins over a concurrent write and suppresses bypass.
    step(1'b0, 1'b1, 1, 16'hAAAA, 0, 0);
    step(1'b1, 1'b1, 1, 16'h5555, 1, 1);
    check("rstw_rd1", 32'(s_rd1[0]), 32'hAAAA);
    check("rstw_bp1", 32'(s_bp1[0]), 32'h0);
    step(1'b0, 1'b0, 0, 16'h0, 1, 5);
    check("rstw_after", 32'(s_rd1[0]), 32'h0);
    check("rstw_r5", 32'(s_rd2[0]), 32'h0);

    // Hardwired zero register.
    step(1'b0, 1'b1, 0, 16'hFFFF, 0, 0);
    check("zr_rd1_now", 32'(s_rd1[1]), 32'h0);
    check("zr_bp1_now", 32'(s_bp1[1]), 32'h0);
    check("nz_rd1_now", 32'(s_rd1[0]), 32'hFFFF);
    step(1'b0, 1'b0, 0, 16'h0, 0, 0);
    check("zr_rd1_next", 32'(s_rd1[1]), 32'h0);
    check("zr_bp1_next", 32'(s_bp1[1]), 32'h0);
    check("nz_rd1_next", 32'(s_rd1[0]), 32'hFFFF);

    // Back-to-back writes to one register tracked through bypass.
    for (int v = 1; v <= 3; v++) begin
      step(1'b0, 1'b1, 7, 16'(v), 0, 7);
      check("b2b_rd2", 32'(s_rd2[0]), 32'(v));
      check("b2b_bp2", 32'(s_bp2[0]), 32'h1);
    end
    step(1'b0, 1'b0, 7, 16'h0, 0, 7);
    check("b2b_hold", 32'(s_rd2[0]), 32'h3);
    check("b2b_hold_bp", 32'(s_bp2[0]), 32'h0);

    // Random traffic against the reference memory.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
           16'($urandom), $urandom_range(0, 7), $urandom_range(0, 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
